// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: stage payloads, control, width/writeback
// encodings and the memory FSM state set.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } memoryWidth_;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2,
    WB_PC4  = 2'd3
  } writebackType_;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2,
    DRAIN   = 2'd3
  } memoryState_;

  typedef struct packed {
    logic          stall;
    logic          flush;
  } control_;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   pcPlus4;
    logic [4:0]    rd;
    logic          memoryReadEnable;
    logic          memoryWriteEnable;
    memoryWidth_   memoryWidth;
    logic          memorySigned;
    logic [31:0]   result;
    logic [31:0]   storeData;
    writebackType_ writebackType;
    logic          valid;
    logic          illegal;
  } executeMemoryPayload_;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   pcPlus4;
    logic [4:0]    rd;
    logic [31:0]   writeData;
    writebackType_ writebackType;
    logic          valid;
    logic          illegal;
    logic          accessFault;
  } memoryWritebackPayload_;

endpackage

// File: rtl/memory_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated data and load
// lane extraction with sign/zero extension.
module memory_lane_align
  import memory_stage_pkg::*;
(
  input  memoryWidth_ i_width,
  input  logic        i_signed,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_storeData,
  input  logic [31:0] i_loadWord,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_storeData,
  output logic [31:0] o_loadData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_loadWord[7:0];
    case (i_addr)
      2'd1:    w_byte = i_loadWord[15:8];
      2'd2:    w_byte = i_loadWord[23:16];
      2'd3:    w_byte = i_loadWord[31:24];
      default: w_byte = i_loadWord[7:0];
    endcase
    w_half = i_addr[1] ? i_loadWord[31:16] : i_loadWord[15:0];

    o_strobe    = 4'b1111;
    o_storeData = i_storeData;
    o_loadData  = i_loadWord;
    case (i_width)
      MEM_BYTE: begin
        o_strobe    = 4'b0001 << i_addr;
        o_storeData = {4{i_storeData[7:0]}};
        o_loadData  = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      MEM_HALF: begin
        o_strobe    = 4'b0011 << i_addr;
        o_storeData = {2{i_storeData[15:0]}};
        o_loadData  = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: load/store over a valid/ready data port with lane
// steering, fault/timeout handling and stall. Option: MEMORY_MISALIGN_CHECK_EN.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  executeMemoryPayload_   executeMemoryPayload,
  input  control_                memoryWritebackControl,
  output memoryWritebackPayload_ memoryWritebackPayload,
  output logic                   memoryStallRequest,
  output logic                   dataRequestValid,
  input  logic                   dataRequestReady,
  output logic                   dataRequestWrite,
  output logic [31:0]            dataRequestAddress,
  output logic [31:0]            dataRequestWriteData,
  output logic [3:0]             dataRequestStrobe,
  input  logic                   dataResponseValid,
  input  logic [31:0]            dataResponseData,
  input  logic                   dataResponseError
);

  localparam int unsigned COUNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);

  memoryState_            r_state;
  executeMemoryPayload_   r_req;
  memoryWritebackPayload_ r_out;
  memoryWritebackPayload_ r_hold;
  logic                   r_holdValid;
  logic                   r_drainReq;
  logic [COUNT_W-1:0]     r_count;

  executeMemoryPayload_   w_src;
  memoryWritebackPayload_ w_pass;
  memoryWritebackPayload_ w_complete;
  memoryWritebackPayload_ w_outNext;
  logic                   w_outFull;
  logic                   w_access;
  logic                   w_misaligned;
  logic                   w_issue;
  logic                   w_respDone;
  logic                   w_fault;
  logic [31:0]            w_loadData;
  logic [31:0]            w_storeData;
  logic [3:0]             w_strobe;

  // Request fields come from the live input only in IDLE; afterwards from the latched copy.
  assign w_src = (r_state == IDLE) ? executeMemoryPayload : r_req;

  memory_lane_align u_align (
    .i_width     (w_src.memoryWidth),
    .i_signed    (w_src.memorySigned),
    .i_addr      (w_src.result[1:0]),
    .i_storeData (w_src.storeData),
    .i_loadWord  (dataResponseData),
    .o_strobe    (w_strobe),
    .o_storeData (w_storeData),
    .o_loadData  (w_loadData)
  );

  always_comb begin
    w_access = executeMemoryPayload.valid && !executeMemoryPayload.illegal &&
               (executeMemoryPayload.memoryReadEnable || executeMemoryPayload.memoryWriteEnable);
`ifdef MEMORY_MISALIGN_CHECK_EN
    case (executeMemoryPayload.memoryWidth)
      MEM_BYTE: w_misaligned = 1'b0;
      MEM_HALF: w_misaligned = w_access && executeMemoryPayload.result[0];
      default:  w_misaligned = w_access && (executeMemoryPayload.result[1:0] != 2'b00);
    endcase
`else
    w_misaligned = 1'b0;
`endif
    w_issue    = (r_state == IDLE) && !r_holdValid && w_access && !w_misaligned;
    w_respDone = dataResponseValid || (r_count == COUNT_LAST);
    w_fault    = dataResponseValid ? dataResponseError : 1'b1;

    w_pass.pc            = executeMemoryPayload.pc;
    w_pass.pcPlus4       = executeMemoryPayload.pcPlus4;
    w_pass.rd            = executeMemoryPayload.rd;
    w_pass.writeData     = executeMemoryPayload.result;
    w_pass.writebackType = executeMemoryPayload.writebackType;
    w_pass.valid         = executeMemoryPayload.valid;
    w_pass.illegal       = executeMemoryPayload.illegal;
    w_pass.accessFault   = w_misaligned;

    w_complete.pc            = r_req.pc;
    w_complete.pcPlus4       = r_req.pcPlus4;
    w_complete.rd            = r_req.rd;
    w_complete.writebackType = r_req.writebackType;
    w_complete.valid         = r_req.valid;
    w_complete.illegal       = r_req.illegal;
    w_complete.accessFault   = w_fault;
    w_complete.writeData     = (w_fault || r_req.memoryWriteEnable || !r_req.memoryReadEnable)
                               ? '0 : w_loadData;

    w_outNext = w_pass;
    w_outFull = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_holdValid) begin
          w_outNext = r_hold;
          w_outFull = 1'b1;
        end else begin
          w_outFull = !w_issue;
        end
      end
      WAIT: begin
        w_outNext = w_complete;
        w_outFull = w_respDone;
      end
      default: ;
    endcase

    case (r_state)
      IDLE:    memoryStallRequest = r_holdValid ? (memoryWritebackControl.stall && !memoryWritebackControl.flush)
                                                : w_issue;
      REQUEST: memoryStallRequest = 1'b1;
      WAIT:    memoryStallRequest = !(w_respDone && (!memoryWritebackControl.stall || memoryWritebackControl.flush));
      default: memoryStallRequest = r_drainReq || !w_respDone;
    endcase

    dataRequestValid     = w_issue || (r_state == REQUEST) || ((r_state == DRAIN) && r_drainReq);
    dataRequestWrite     = w_src.memoryWriteEnable;
    dataRequestAddress   = {w_src.result[31:2], 2'b00};
    dataRequestWriteData = w_storeData;
    dataRequestStrobe    = w_strobe;
  end

  assign memoryWritebackPayload = r_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_out       <= '0;
      r_hold      <= '0;
      r_holdValid <= 1'b0;
      r_drainReq  <= 1'b0;
      r_count     <= '0;
    end else begin
      if (memoryWritebackControl.flush) begin
        r_out.valid <= 1'b0;
      end else if (!memoryWritebackControl.stall) begin
        if (w_outFull) r_out <= w_outNext;
        else           r_out.valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (r_holdValid) begin
            if (memoryWritebackControl.flush || !memoryWritebackControl.stall) r_holdValid <= 1'b0;
          end else if (w_issue) begin
            r_req   <= executeMemoryPayload;
            r_state <= dataRequestReady ? WAIT : REQUEST;
          end
        end
        REQUEST: begin
          r_count <= '0;
          if (memoryWritebackControl.flush) begin
            r_state    <= DRAIN;
            r_drainReq <= !dataRequestReady;
          end else if (dataRequestReady) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_count <= r_count + COUNT_W'(1);
          if (w_respDone) begin
            r_state <= IDLE;
            if (!memoryWritebackControl.flush && memoryWritebackControl.stall) begin
              r_hold      <= w_complete;
              r_holdValid <= 1'b1;
            end
          end else if (memoryWritebackControl.flush) begin
            r_state    <= DRAIN;
            r_drainReq <= 1'b0;
          end
        end
        default: begin
          if (r_drainReq) begin
            r_count <= '0;
            if (dataRequestReady) r_drainReq <= 1'b0;
          end else begin
            r_count <= r_count + COUNT_W'(1);
            if (w_respDone) r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage with a transaction-level
// reference model (latency arithmetic + lane/extension rules).
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int T = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  executeMemoryPayload_   exPayload;
  control_                ctl;
  memoryWritebackPayload_ wbPayload;
  logic                   stallReq;
  logic                   reqValid;
  logic                   reqReady;
  logic                   reqWrite;
  logic [31:0]            reqAddr;
  logic [31:0]            reqWdata;
  logic [3:0]             reqStrb;
  logic                   rspValid;
  logic [31:0]            rspData;
  logic                   rspErr;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  memory_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .executeMemoryPayload   (exPayload),
    .memoryWritebackControl (ctl),
    .memoryWritebackPayload (wbPayload),
    .memoryStallRequest     (stallReq),
    .dataRequestValid       (reqValid),
    .dataRequestReady       (reqReady),
    .dataRequestWrite       (reqWrite),
    .dataRequestAddress     (reqAddr),
    .dataRequestWriteData   (reqWdata),
    .dataRequestStrobe      (reqStrb),
    .dataResponseValid      (rspValid),
    .dataResponseData       (rspData),
    .dataResponseError      (rspErr)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(memoryWidth_ w, logic sgn, logic [1:0] a, logic [31:0] word);
    logic [31:0] v;
    case (w)
      MEM_BYTE: begin
        v = (word >> (8 * a)) & 32'hFF;
        if (sgn && v >= 32'd128) v = v - 32'd256;
      end
      MEM_HALF: begin
        v = (word >> (16 * a[1])) & 32'hFFFF;
        if (sgn && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_strobe(memoryWidth_ w, logic [1:0] a);
    int s;
    case (w)
      MEM_BYTE: s = 1 << a;
      MEM_HALF: s = 3 << a;
      default:  s = 15;
    endcase
    return 4'(s & 15);
  endfunction

  function automatic logic [31:0] model_wdata(memoryWidth_ w, logic [31:0] d);
    case (w)
      MEM_BYTE: return (d & 32'hFF) * 32'h01010101;
      MEM_HALF: return (d & 32'hFFFF) * 32'h00010001;
      default:  return d;
    endcase
  endfunction

  // d < 0: memory never answers. f >= 0: flush on that WAIT cycle. ostall: output stall cycles from the response.
  task automatic run_op(input string tag, input executeMemoryPayload_ p, input int r, input int d,
                        input logic err, input logic [31:0] rdata, input int f, input int ostall);
    bit access, mis, bus, tmo, done;
    int dEff, expCycles, c, acc, stallHigh, w;
    memoryWritebackPayload_ exp;

    access = p.valid && !p.illegal && (p.memoryReadEnable || p.memoryWriteEnable);
    mis = 1'b0;
`ifdef MEMORY_MISALIGN_CHECK_EN
    mis = access && ((p.memoryWidth == MEM_HALF && p.result[0]) ||
                     (p.memoryWidth == MEM_WORD && p.result[1:0] != 2'b00));
`endif
    bus  = access && !mis;
    tmo  = bus && (d < 0);
    dEff = tmo ? T - 1 : d;

    exp.pc = p.pc; exp.pcPlus4 = p.pcPlus4; exp.rd = p.rd;
    exp.writebackType = p.writebackType; exp.illegal = p.illegal;
    exp.valid = p.valid; exp.accessFault = 1'b0; exp.writeData = p.result;
    if (mis) begin
      exp.accessFault = 1'b1;
    end else if (bus) begin
      if (tmo || err) begin
        exp.accessFault = 1'b1;
        exp.writeData   = '0;
      end else if (p.memoryWriteEnable) begin
        exp.writeData = '0;
      end else begin
        exp.writeData = model_load(p.memoryWidth, p.memorySigned, p.result[1:0], rdata);
      end
    end
    expCycles = bus ? (r + 1 + dEff + 1 + ostall) : 1;

    exPayload = p;
    c = 0; acc = -1; stallHigh = 0; done = 1'b0;
    while (!done && c < 60) begin
      w = (acc >= 0) ? (c - acc - 1) : -1;
      reqReady  = bus && (acc < 0) && (c >= r);
      rspValid  = !tmo && (acc >= 0) && (w == d);
      rspErr    = rspValid && err;
      rspData   = rspValid ? rdata : $urandom();
      ctl.flush = (f >= 0) && (acc >= 0) && (w == f);
      ctl.stall = (ostall > 0) && (acc >= 0) && (w >= dEff) && (w < dEff + ostall);
      #1;
      check({tag, "/req_valid"}, 128'(reqValid), 128'(bus && acc < 0));
      if (reqValid && bus && acc < 0) begin
        check({tag, "/req_addr"}, 128'(reqAddr), 128'(p.result & 32'hFFFF_FFFC));
        check({tag, "/req_write"}, 128'(reqWrite), 128'(p.memoryWriteEnable));
        if (p.memoryWriteEnable) begin
          check({tag, "/req_strobe"}, 128'(reqStrb), 128'(model_strobe(p.memoryWidth, p.result[1:0])));
          check({tag, "/req_wdata"}, 128'(reqWdata), 128'(model_wdata(p.memoryWidth, p.storeData)));
        end
        if (reqReady) acc = c;
      end
      if (stallReq) stallHigh++;
      else          done = 1'b1;
      @(posedge clock); #1;
      c++;
    end

    check({tag, "/completed"}, 128'(done), 128'(1));
    check({tag, "/cycles"}, 128'(c), 128'(expCycles));
    check({tag, "/stall_cycles"}, 128'(stallHigh), 128'(expCycles - 1));
    if (bus && f >= 0) check({tag, "/flushed_valid"}, 128'(wbPayload.valid), 128'(0));
    else               check({tag, "/payload"}, 128'(wbPayload), 128'(exp));

    reqReady = 1'b0; rspValid = 1'b0; rspErr = 1'b0; ctl = '0;
  endtask

  function automatic executeMemoryPayload_ mk(logic re, logic we, memoryWidth_ wd, logic sgn,
                                              logic [31:0] addr, logic [31:0] sd);
    executeMemoryPayload_ p;
    p.pc = $urandom() & 32'hFFFF_FFFC;
    p.pcPlus4 = p.pc + 32'd4;
    p.rd = 5'($urandom_range(1, 31));
    p.memoryReadEnable = re;
    p.memoryWriteEnable = we;
    p.memoryWidth = wd;
    p.memorySigned = sgn;
    p.result = addr;
    p.storeData = sd;
    p.writebackType = we ? WB_NONE : (re ? WB_LOAD : WB_ALU);
    p.valid = 1'b1;
    p.illegal = 1'b0;
    return p;
  endfunction

  initial begin
    executeMemoryPayload_ p;
    int r, d, f, os, kind;
    logic err;

    reset = 1'b1;
    exPayload = '0; ctl = '0;
    reqReady = 1'b0; rspValid = 1'b0; rspData = '0; rspErr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset/payload", 128'(wbPayload), 128'(0));
    check("reset/stall", 128'(stallReq), 128'(0));
    check("reset/req_valid", 128'(reqValid), 128'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("lb_signed", mk(1, 0, MEM_BYTE, 1, 32'h1003, 0), 0, 0, 0, 32'hAB00_0000, -1, 0);
    run_op("sh_0x2002", mk(0, 1, MEM_HALF, 0, 32'h2002, 32'hCAFE_1234), 0, 0, 0, 32'h0, -1, 0);
    run_op("lw_slow", mk(1, 0, MEM_WORD, 0, 32'h4000, 0), 3, 2, 0, 32'h1357_9BDF, -1, 0);
    run_op("lw_flush", mk(1, 0, MEM_WORD, 0, 32'h4004, 0), 0, 2, 0, 32'hDEAD_BEEF, 1, 0);
    p = mk(0, 0, MEM_WORD, 0, 32'h0BAD_F00D, 0);
    run_op("alu_after_flush", p, 0, 0, 0, 0, -1, 0);
    run_op("lw_timeout", mk(1, 0, MEM_WORD, 0, 32'h5000, 0), 1, -1, 0, 0, -1, 0);
    run_op("lh_outstall", mk(1, 0, MEM_HALF, 0, 32'h6002, 0), 0, 1, 0, 32'h8001_7FFF, -1, 2);
    run_op("lbu_buserr", mk(1, 0, MEM_BYTE, 0, 32'h7001, 0), 2, 0, 1, 32'hFFFF_FFFF, -1, 0);
    run_op("lw_0x3001", mk(1, 0, MEM_WORD, 0, 32'h3001, 0), 0, 0, 0, 32'h89AB_CDEF, -1, 0);
    p = mk(1, 0, MEM_WORD, 0, 32'h8000, 0);
    p.illegal = 1'b1;
    run_op("illegal_pass", p, 0, 0, 0, 0, -1, 0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      p = mk(kind >= 2 && kind <= 5, kind >= 6, memoryWidth_'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), $urandom(), $urandom());
      if (kind < 2) begin
        p.valid = 1'($urandom_range(0, 1));
        p.illegal = 1'($urandom_range(0, 1));
        p.memoryReadEnable = p.illegal;
      end
      r   = $urandom_range(0, 3);
      d   = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, T - 1);
      err = ($urandom_range(0, 9) == 0);
      f   = -1;
      os  = 0;
      if ($urandom_range(0, 9) == 0) f = $urandom_range(0, (d < 0) ? T - 1 : d);
      else if ($urandom_range(0, 7) == 0) os = $urandom_range(1, 3);
      run_op("random", p, r, d, err, $urandom(), f, os);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
